// File: rtl/demux_seq_pkg.sv
// Shared types for the demux round-robin sequencer.
package demux_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultN = 8;

endpackage

// File: rtl/rr_next_chan.sv
// Combinational scan: lowest set bit of mask_i strictly above ptr_i,
// or the lowest set bit overall when lowest_i is high.
module rr_next_chan #(
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     mask_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             lowest_i,
    output logic [SEL_W-1:0] nxt_o,
    output logic             found_o
);

    // Descending loop so the last hit written is the lowest qualifying index.
    always_comb begin
        nxt_o   = '0;
        found_o = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask_i[i] && (lowest_i || i > int'(ptr_i))) begin
                nxt_o   = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_sequencer.sv
// Round-robin I/S sequencer feeding a 1-to-N demux.
// DEMUX_SEQ_CONTINUOUS_EN: frames restart automatically from the live chan_en.
module demux_rr_sequencer
    import demux_seq_pkg::*;
#(
    parameter  int unsigned N     = DefaultN,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     chan_en,
    input  logic             in_valid,
    input  logic             in_data,
    output logic             in_ready,
    output logic             I,
    output logic [SEL_W-1:0] S,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done
);

    state_e           state_q;
    logic [N-1:0]     mask_q;
    logic [SEL_W-1:0] ptr_q;
    logic             i_q;
    logic [SEL_W-1:0] s_q;
    logic             out_valid_q;
    logic             frame_done_q;

    logic [SEL_W-1:0] low_idx;
    logic             low_found;
    logic [SEL_W-1:0] nxt_idx;
    logic             nxt_found;
    logic [N-1:0]     ptr_oh;

    rr_next_chan #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_low_chan (
        .mask_i   (chan_en),
        .ptr_i    ('0),
        .lowest_i (1'b1),
        .nxt_o    (low_idx),
        .found_o  (low_found)
    );

    // mask_q still holds ptr_q's bit, so "above ptr" skips it naturally.
    rr_next_chan #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_next_chan (
        .mask_i   (mask_q),
        .ptr_i    (ptr_q),
        .lowest_i (1'b0),
        .nxt_o    (nxt_idx),
        .found_o  (nxt_found)
    );

    assign ptr_oh = {{(N - 1){1'b0}}, 1'b1} << ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            ptr_q        <= '0;
            i_q          <= 1'b0;
            s_q          <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            i_q          <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && low_found) begin
                        state_q <= StRun;
                        mask_q  <= chan_en;
                        ptr_q   <= low_idx;
                    end
                end
                StRun: begin
                    if (in_valid) begin
                        i_q         <= in_data;
                        s_q         <= ptr_q;
                        out_valid_q <= 1'b1;
                        mask_q      <= mask_q & ~ptr_oh;
                        if (nxt_found) begin
                            ptr_q <= nxt_idx;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    frame_done_q <= 1'b1;
`ifdef DEMUX_SEQ_CONTINUOUS_EN
                    if (low_found) begin
                        state_q <= StRun;
                        mask_q  <= chan_en;
                        ptr_q   <= low_idx;
                    end else begin
                        state_q <= StIdle;
                        mask_q  <= '0;
                        ptr_q   <= '0;
                    end
`else
                    state_q <= StIdle;
                    mask_q  <= '0;
                    ptr_q   <= '0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = (state_q == StRun);
    assign busy       = (state_q != StIdle);
    assign I          = i_q;
    assign S          = s_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_rr_sequencer.sv
// Self-checking bench for demux_rr_sequencer against a channel-queue reference model.
module tb_demux_rr_sequencer;

    localparam int unsigned N     = 8;
    localparam int unsigned SEL_W = $clog2(N);

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     chan_en;
    logic             in_valid;
    logic             in_data;
    logic             in_ready;
    logic             I;
    logic [SEL_W-1:0] S;
    logic             out_valid;
    logic             busy;
    logic             frame_done;

    demux_rr_sequencer #(
        .N (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .chan_en    (chan_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .I          (I),
        .S          (S),
        .out_valid  (out_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model: a frame is the ascending list of enabled channels still to serve.
    int               pend[$];
    bit               m_active;
    bit               m_done;
    logic             exp_i;
    logic [SEL_W-1:0] exp_s;
    logic             exp_ov;
    logic             exp_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_frame(input logic [N-1:0] en);
        pend.delete();
        for (int c = 0; c < int'(N); c++) begin
            if (en[c]) pend.push_back(c);
        end
        m_active = (pend.size() != 0);
        m_done   = 1'b0;
    endtask

    task automatic model_reset();
        pend.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
        exp_i    = 1'b0;
        exp_s    = '0;
        exp_ov   = 1'b0;
        exp_fd   = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic [N-1:0] en, input logic v,
                              input logic d);
        exp_i  = 1'b0;
        exp_ov = 1'b0;
        exp_fd = 1'b0;
        if (!m_active) begin
            if (st) load_frame(en);
        end else if (m_done) begin
            exp_fd = 1'b1;
`ifdef DEMUX_SEQ_CONTINUOUS_EN
            load_frame(en);
`else
            m_active = 1'b0;
            m_done   = 1'b0;
`endif
        end else if (v) begin
            exp_i  = d;
            exp_s  = SEL_W'(pend.pop_front());
            exp_ov = 1'b1;
            if (pend.size() == 0) m_done = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check #1 after it.
    task automatic cycle(input logic st, input logic [N-1:0] en, input logic v, input logic d);
        start    = st;
        chan_en  = en;
        in_valid = v;
        in_data  = d;
        #1;
        chk("in_ready_pre", {31'd0, in_ready}, {31'd0, m_active && !m_done});
        @(posedge clk);
        model_edge(st, en, v, d);
        #1;
        chk("I", {31'd0, I}, {31'd0, exp_i});
        chk("S", 32'(S), 32'(exp_s));
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_active && !m_done});
    endtask

    // Called at edge+1; asserts rst off-edge and checks outputs clear before any clock.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_I", {31'd0, I}, 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] bits8;
    logic [6:0] gap_pat;

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        chan_en  = '0;
        in_valid = 1'b0;
        in_data  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Full mask, continuous valid.
        bits8 = 8'b0100_1101;
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) cycle(1'b0, 8'hFF, 1'b1, bits8[k]);
        repeat (3) cycle(1'b0, 8'hFF, 1'b1, 1'b1);

        // Sparse mask 2,5,7.
        cycle(1'b1, 8'b1010_0100, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 8'b1010_0100, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 8'b1010_0100, 1'b0, 1'b0);

        // Empty mask start is ignored; then single top channel.
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'h80, 1'b0, 1'b0);
        cycle(1'b0, 8'h80, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 8'h80, 1'b0, 1'b0);

        // Valid gaps with a second start mid-frame.
        gap_pat = 7'b1011001;
        cycle(1'b1, 8'h0F, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cycle((k == 2) ? 1'b1 : 1'b0, 8'h0F, gap_pat[k], 1'($urandom));
        end
        repeat (3) cycle(1'b0, 8'h0F, 1'b0, 1'b0);

        // Reset after two transfers, then single channel 0.
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        cycle(1'b0, 8'hFF, 1'b1, 1'b1);
        cycle(1'b0, 8'hFF, 1'b1, 1'b1);
        do_reset();
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b0, 8'h01, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 8'h01, 1'b0, 1'b0);

        // Two-channel mask streamed, mask cleared mid-frame.
        cycle(1'b1, 8'h03, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 8'h03, 1'b1, 1'($urandom));
        cycle(1'b0, 8'h03, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0,
                      ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                      $urandom_range(0, 2) != 0,
                      1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
